// File: rtl/sc_life_pkg.sv
// Shared encodings for the Frogger life-counter sequencing controller:
// FSM state codes, death-cause codes and requester priority indices.
package sc_life_pkg;

  // Controller states, 3-bit binary encoding.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_HIT      = 3'd3,
    ST_CHECK    = 3'd4,
    ST_RESPAWN  = 3'd5,
    ST_GAMEOVER = 3'd6
  } life_state_t;

  // Cause of the most recent death, as shown on cause_OutBUS.
  typedef logic [1:0] cause_t;
  localparam cause_t CAUSE_NONE    = 2'b00;
  localparam cause_t CAUSE_CAR     = 2'b01;
  localparam cause_t CAUSE_RIVER   = 2'b10;
  localparam cause_t CAUSE_TIMEOUT = 2'b11;

  // Requester bit positions; a lower index wins when edges coincide.
  localparam int REQ_CAR     = 0;
  localparam int REQ_RIVER   = 1;
  localparam int REQ_TIMEOUT = 2;
  localparam int REQ_COUNT   = 3;

  // Fixed-priority pick of the winning requester, returned as its cause code.
  function automatic cause_t pick_cause(input logic [REQ_COUNT-1:0] edges);
    if (edges[REQ_CAR])          return CAUSE_CAR;
    else if (edges[REQ_RIVER])   return CAUSE_RIVER;
    else if (edges[REQ_TIMEOUT]) return CAUSE_TIMEOUT;
    else                         return CAUSE_NONE;
  endfunction

endpackage

// File: rtl/sc_life_controller_if.sv
// Signal bundle between the life controller and its surroundings
// (death requesters, start button, life counter and status consumers).
interface sc_life_controller_if #(
  parameter int LIFE_DATAWIDTH = 8
);
  import sc_life_pkg::*;

  logic                      start_InLow;
  logic                      carhit_InHigh;
  logic                      river_InHigh;
  logic                      timeout_InHigh;
  logic [LIFE_DATAWIDTH-1:0] lifecount_InBUS;

  logic                      upcount_OutLow;
  logic                      clear_OutHigh;
  logic                      playing_OutHigh;
  logic                      respawning_OutHigh;
  logic                      gameover_OutHigh;
  cause_t                    cause_OutBUS;
  logic [LIFE_DATAWIDTH-1:0] livesleft_OutBUS;

  // Controller side.
  modport master (
    input  start_InLow, carhit_InHigh, river_InHigh, timeout_InHigh, lifecount_InBUS,
    output upcount_OutLow, clear_OutHigh, playing_OutHigh, respawning_OutHigh,
           gameover_OutHigh, cause_OutBUS, livesleft_OutBUS
  );

  // Game-logic / counter side.
  modport slave (
    output start_InLow, carhit_InHigh, river_InHigh, timeout_InHigh, lifecount_InBUS,
    input  upcount_OutLow, clear_OutHigh, playing_OutHigh, respawning_OutHigh,
           gameover_OutHigh, cause_OutBUS, livesleft_OutBUS
  );

endinterface

// File: rtl/sc_life_respawn_timer.sv
// Loadable down-counter timing the respawn/invincibility window.
// Loading RESPAWN_CYCLES-1 and stopping at zero gives a window of exactly
// RESPAWN_CYCLES cycles when the owner leaves on the zero flag.
module sc_life_respawn_timer #(
  parameter int RESPAWN_CYCLES = 50_000_000
) (
  input  logic SC_upLIFECOUNTER_CLOCK_50,
  input  logic SC_upLIFECOUNTER_RESET_InHigh,
  input  logic i_load,
  input  logic i_dec,
  output logic o_zero
);

  // A single-cycle window still needs one bit of storage.
  localparam int TIMER_W = (RESPAWN_CYCLES > 1) ? $clog2(RESPAWN_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] LOAD_VALUE = TIMER_W'(RESPAWN_CYCLES - 1);

  logic [TIMER_W-1:0] r_count;

  // Load on request, otherwise count down to zero and hold there.
  always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
    if (SC_upLIFECOUNTER_RESET_InHigh) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LOAD_VALUE;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - TIMER_W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/sc_life_controller.sv
// Frogger life-counter sequencing controller: arbitrates car/river/timeout
// death requests, issues one upcount pulse per accepted death, reads the
// updated count back and chooses between a timed respawn and game-over.
module sc_life_controller
  import sc_life_pkg::*;
#(
  parameter int LIFE_DATAWIDTH = 8,
  parameter int MAX_LIVES      = 3,
  parameter int RESPAWN_CYCLES = 50_000_000
) (
  input  logic                 SC_upLIFECOUNTER_CLOCK_50,
  input  logic                 SC_upLIFECOUNTER_RESET_InHigh,
  sc_life_controller_if.master life_bus
);

  localparam logic [LIFE_DATAWIDTH-1:0] MAX_LIVES_W = LIFE_DATAWIDTH'(MAX_LIVES);

  life_state_t          r_state;
  life_state_t          w_next_state;
  logic [REQ_COUNT-1:0] w_req;
  logic [REQ_COUNT-1:0] r_req_q;
  logic [REQ_COUNT-1:0] w_req_edge;
  cause_t               r_cause;
  logic                 r_clear;
  logic                 w_out_of_lives;
  logic                 w_timer_load;
  logic                 w_timer_dec;
  logic                 w_timer_zero;

  assign w_req[REQ_CAR]     = life_bus.carhit_InHigh;
  assign w_req[REQ_RIVER]   = life_bus.river_InHigh;
  assign w_req[REQ_TIMEOUT] = life_bus.timeout_InHigh;

  // A request counts only on its rising edge; levels held through RESPAWN
  // must drop and rise again before they can kill the frog.
  assign w_req_edge     = w_req & ~r_req_q;
  assign w_out_of_lives = (life_bus.lifecount_InBUS >= MAX_LIVES_W);

  // State register.
  always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (SC_upLIFECOUNTER_RESET_InHigh) r_state <= ST_IDLE;
    else                               r_state <= w_next_state;
  end

  // Next-state decision.
  always_comb begin
    // NOTE: defaulting before the case keeps this block free of latches.
    w_next_state = r_state;
    case (r_state)
      ST_IDLE, ST_GAMEOVER: if (!life_bus.start_InLow) w_next_state = ST_CLEAR;
      ST_CLEAR:             w_next_state = ST_PLAY;
      ST_PLAY:              if (|w_req_edge) w_next_state = ST_HIT;
      ST_HIT:               w_next_state = ST_CHECK;
      ST_CHECK:             w_next_state = w_out_of_lives ? ST_GAMEOVER : ST_RESPAWN;
      ST_RESPAWN:           if (w_timer_zero) w_next_state = ST_PLAY;
      default:              w_next_state = ST_IDLE;
    endcase
  end

  // Moore status decodes of the state register.
  always_comb begin
    life_bus.upcount_OutLow     = 1'b1;
    life_bus.playing_OutHigh    = 1'b0;
    life_bus.respawning_OutHigh = 1'b0;
    life_bus.gameover_OutHigh   = 1'b0;
    case (r_state)
      ST_HIT:      life_bus.upcount_OutLow     = 1'b0;
      ST_PLAY:     life_bus.playing_OutHigh    = 1'b1;
      ST_RESPAWN:  life_bus.respawning_OutHigh = 1'b1;
      ST_GAMEOVER: life_bus.gameover_OutHigh   = 1'b1;
      default:     ;
    endcase
  end

  // Clear pulse comes from its own flop, set while entering CLEAR, so the
  // counter's asynchronous reset never sees decode glitches.
  always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
    if (SC_upLIFECOUNTER_RESET_InHigh) r_clear <= 1'b0;
    else                               r_clear <= (w_next_state == ST_CLEAR);
  end

  // Edge-detector history, refreshed in every state.
  always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
    if (SC_upLIFECOUNTER_RESET_InHigh) r_req_q <= '0;
    else                               r_req_q <= w_req;
  end

  // Cause register: wiped by CLEAR, latches the priority winner in PLAY.
  always_ff @(posedge SC_upLIFECOUNTER_CLOCK_50 or posedge SC_upLIFECOUNTER_RESET_InHigh) begin
    if (SC_upLIFECOUNTER_RESET_InHigh) begin
      r_cause <= CAUSE_NONE;
    end else if (r_state == ST_CLEAR) begin
      r_cause <= CAUSE_NONE;
    end else if ((r_state == ST_PLAY) && (|w_req_edge)) begin
      r_cause <= pick_cause(w_req_edge);
    end
  end

  assign w_timer_load = (r_state == ST_CHECK) && !w_out_of_lives;
  assign w_timer_dec  = (r_state == ST_RESPAWN);

  sc_life_respawn_timer #(
    .RESPAWN_CYCLES(RESPAWN_CYCLES)
  ) u_respawn_timer (
    .SC_upLIFECOUNTER_CLOCK_50    (SC_upLIFECOUNTER_CLOCK_50),
    .SC_upLIFECOUNTER_RESET_InHigh(SC_upLIFECOUNTER_RESET_InHigh),
    .i_load                       (w_timer_load),
    .i_dec                        (w_timer_dec),
    .o_zero                       (w_timer_zero)
  );

  assign life_bus.clear_OutHigh    = r_clear;
  assign life_bus.cause_OutBUS     = r_cause;
  assign life_bus.livesleft_OutBUS = w_out_of_lives ? '0 : (MAX_LIVES_W - life_bus.lifecount_InBUS);

endmodule

// File: tb/tb_sc_life_controller.sv
// Bench for sc_life_controller with a small stand-in for SC_upLIFECOUNTER.
// A cycle model tracks game progress as counters (deaths, respawn cycles
// left, post-death stage) and every output is compared after each edge.
module tb_sc_life_controller;

  localparam int DW   = 8;
  localparam int MAXL = 3;
  localparam int RESP = 4;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  sc_life_controller_if #(.LIFE_DATAWIDTH(DW)) bus ();

  sc_life_controller #(
    .LIFE_DATAWIDTH(DW),
    .MAX_LIVES     (MAXL),
    .RESPAWN_CYCLES(RESP)
  ) u_dut (
    .SC_upLIFECOUNTER_CLOCK_50    (clk),
    .SC_upLIFECOUNTER_RESET_InHigh(rst),
    .life_bus                     (bus)
  );

  // Life counter: reset by system reset OR clear, counts on low upcount.
  logic [DW-1:0] lifecount;
  logic          cnt_rst;
  assign cnt_rst             = rst | bus.clear_OutHigh;
  assign bus.lifecount_InBUS = lifecount;

  always @(posedge clk or posedge cnt_rst) begin
    if (cnt_rst)                  lifecount <= '0;
    else if (!bus.upcount_OutLow) lifecount <= lifecount + 8'd1;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: game phase 0=not started, 1=running, 2=over; deaths so far;
  // post-death stage 1=pulse cycle, 2=readback cycle; respawn cycles left.
  int         m_game      = 0;
  bit         m_clear     = 1'b0;
  int         m_hit_stage = 0;
  int         m_resp_left = 0;
  int         m_deaths    = 0;
  int         m_cause     = 0;
  logic [2:0] m_prev      = 3'b000;

  task automatic model_step();
    logic [2:0] req;
    logic [2:0] e;
    req = {bus.timeout_InHigh, bus.river_InHigh, bus.carhit_InHigh};
    if (rst) begin
      m_game = 0; m_clear = 1'b0; m_hit_stage = 0; m_resp_left = 0;
      m_deaths = 0; m_cause = 0; m_prev = 3'b000;
      return;
    end
    e      = req & ~m_prev;
    m_prev = req;
    if (m_clear) begin
      m_clear = 1'b0;
      m_cause = 0;
    end else if (m_game != 1) begin
      if (!bus.start_InLow) begin
        m_clear  = 1'b1;
        m_game   = 1;
        m_deaths = 0;
      end
    end else if (m_hit_stage == 1) begin
      m_hit_stage = 2;
      m_deaths++;
    end else if (m_hit_stage == 2) begin
      m_hit_stage = 0;
      if (m_deaths >= MAXL) m_game = 2;
      else                  m_resp_left = RESP;
    end else if (m_resp_left > 0) begin
      m_resp_left--;
    end else if (e != 3'b000) begin
      m_hit_stage = 1;
      m_cause     = e[0] ? 1 : (e[1] ? 2 : 3);
    end
  endtask

  task automatic compare_outputs();
    bit pulse;
    pulse = (m_game == 1) && (m_hit_stage == 1);
    check("upcount",    32'(bus.upcount_OutLow),     32'(!pulse));
    check("clear",      32'(bus.clear_OutHigh),      32'(m_clear));
    check("playing",    32'(bus.playing_OutHigh),
          32'((m_game == 1) && !m_clear && (m_hit_stage == 0) && (m_resp_left == 0)));
    check("respawning", 32'(bus.respawning_OutHigh), 32'(m_resp_left > 0));
    check("gameover",   32'(bus.gameover_OutHigh),   32'(m_game == 2));
    check("cause",      32'(bus.cause_OutBUS),       32'(m_cause));
    check("lifecount",  32'(lifecount),              32'(m_deaths));
    check("livesleft",  32'(bus.livesleft_OutBUS),   32'((m_deaths >= MAXL) ? 0 : MAXL - m_deaths));
  endtask

  // Model advances on each edge; outputs are compared 1 time unit later.
  always @(posedge clk) begin
    model_step();
    #1;
    compare_outputs();
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int pulses;
  int resp_cycles;

  initial begin
    rst = 1'b1;
    bus.start_InLow    = 1'b1;
    bus.carhit_InHigh  = 1'b0;
    bus.river_InHigh   = 1'b0;
    bus.timeout_InHigh = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state.
    check("rst_upcount",   32'(bus.upcount_OutLow),   32'd1);
    check("rst_playing",   32'(bus.playing_OutHigh),  32'd0);
    check("rst_gameover",  32'(bus.gameover_OutHigh), 32'd0);
    check("rst_livesleft", 32'(bus.livesleft_OutBUS), 32'd3);
    check("rst_cause",     32'(bus.cause_OutBUS),     32'd0);

    // 1: start for one cycle -> CLEAR then PLAY.
    bus.start_InLow = 1'b0;
    tick(1);
    check("t1_clear_pulse", 32'(bus.clear_OutHigh), 32'd1);
    bus.start_InLow = 1'b1;
    tick(1);
    check("t1_clear_done", 32'(bus.clear_OutHigh),    32'd0);
    check("t1_playing",    32'(bus.playing_OutHigh),  32'd1);
    check("t1_livesleft",  32'(bus.livesleft_OutBUS), 32'd3);

    // 2: car held for 10 cycles -> one death, 4 respawn cycles.
    pulses = 0; resp_cycles = 0;
    bus.carhit_InHigh = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!bus.upcount_OutLow)    pulses++;
      if (bus.respawning_OutHigh) resp_cycles++;
    end
    bus.carhit_InHigh = 1'b0;
    check("t2_pulses",    32'(pulses),               32'd1);
    check("t2_respawn",   32'(resp_cycles),          32'd4);
    check("t2_count",     32'(lifecount),            32'd1);
    check("t2_cause",     32'(bus.cause_OutBUS),     32'd1);
    check("t2_playing",   32'(bus.playing_OutHigh),  32'd1);
    check("t2_livesleft", 32'(bus.livesleft_OutBUS), 32'd2);
    tick(2);

    // 3+4: river and timeout together, then a timeout pulse during RESPAWN.
    pulses = 0; resp_cycles = 0;
    bus.river_InHigh   = 1'b1;
    bus.timeout_InHigh = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (!bus.upcount_OutLow)    pulses++;
      if (bus.respawning_OutHigh) resp_cycles++;
      if (i == 1) begin
        bus.river_InHigh   = 1'b0;
        bus.timeout_InHigh = 1'b0;
      end
      if (i == 2) bus.timeout_InHigh = 1'b1;
      if (i == 3) bus.timeout_InHigh = 1'b0;
    end
    check("t3_pulses",  32'(pulses),              32'd1);
    check("t3_cause",   32'(bus.cause_OutBUS),    32'd2);
    check("t3_count",   32'(lifecount),           32'd2);
    check("t4_respawn", 32'(resp_cycles),         32'd4);
    check("t4_playing", 32'(bus.playing_OutHigh), 32'd1);
    tick(2);

    // 5: third death -> game over; requests ignored; restart clears.
    bus.carhit_InHigh = 1'b1;
    tick(4);
    bus.carhit_InHigh = 1'b0;
    check("t5_gameover",  32'(bus.gameover_OutHigh), 32'd1);
    check("t5_livesleft", 32'(bus.livesleft_OutBUS), 32'd0);
    check("t5_count",     32'(lifecount),            32'd3);
    check("t5_cause",     32'(bus.cause_OutBUS),     32'd1);
    pulses = 0;
    bus.river_InHigh = 1'b1;
    tick(1);
    if (!bus.upcount_OutLow) pulses++;
    bus.river_InHigh   = 1'b0;
    bus.timeout_InHigh = 1'b1;
    tick(1);
    if (!bus.upcount_OutLow) pulses++;
    bus.timeout_InHigh = 1'b0;
    tick(2);
    check("t5_ignored_pulses", 32'(pulses),               32'd0);
    check("t5_still_over",     32'(bus.gameover_OutHigh), 32'd1);
    check("t5_count_held",     32'(lifecount),            32'd3);
    bus.start_InLow = 1'b0;
    tick(1);
    bus.start_InLow = 1'b1;
    check("t5_clear",     32'(bus.clear_OutHigh),    32'd1);
    check("t5_cleared",   32'(lifecount),            32'd0);
    tick(1);
    check("t5_replay",    32'(bus.playing_OutHigh),  32'd1);
    check("t5_lives_new", 32'(bus.livesleft_OutBUS), 32'd3);
    check("t5_cause_new", 32'(bus.cause_OutBUS),     32'd0);

    // 6: reset asserted during HIT aborts at once.
    bus.carhit_InHigh = 1'b1;
    tick(1);
    check("t6_in_hit", 32'(bus.upcount_OutLow), 32'd0);
    rst = 1'b1;
    #1;
    check("t6_upcount",    32'(bus.upcount_OutLow),     32'd1);
    check("t6_playing",    32'(bus.playing_OutHigh),    32'd0);
    check("t6_respawning", 32'(bus.respawning_OutHigh), 32'd0);
    check("t6_gameover",   32'(bus.gameover_OutHigh),   32'd0);
    check("t6_clear",      32'(bus.clear_OutHigh),      32'd0);
    check("t6_cause",      32'(bus.cause_OutBUS),       32'd0);
    check("t6_count",      32'(lifecount),              32'd0);
    check("t6_livesleft",  32'(bus.livesleft_OutBUS),   32'd3);
    tick(2);
    bus.carhit_InHigh = 1'b0;
    rst = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
